// File: rtl/lock_ctrl.sv
// Access controller behind the 4-digit code matcher: qualifies match with enter,
// opens the lock, counts wrong entries and enforces a timed lockout with alarm.
module lock_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int TRY_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match,
  input  logic             enter,
  input  logic             relock,
  output logic             unlocked,
  output logic             alarm,
  output logic             good_pulse,
  output logic             bad_pulse,
  output logic [TRY_W-1:0] fail_count
);

  localparam int TMAX    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  // One extra bit so the increment can be compared against MAX_TRIES without wrapping.
  localparam logic [TRY_W:0]     TRIES_LIMIT  = (TRY_W + 1)'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_LOCKED  = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TRY_W-1:0]   fail_q, fail_d;
  logic [TRY_W:0]     fail_inc;
  logic               unlocked_q, unlocked_d;
  logic               alarm_q, alarm_d;
  logic               good_q, good_d;
  logic               bad_q, bad_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    good_d   = 1'b0;
    bad_d    = 1'b0;
    fail_inc = {1'b0, fail_q} + {{TRY_W{1'b0}}, 1'b1};

    case (state_q)
      S_LOCKED: begin
        if (enter) begin
          if (match) begin
            state_d = S_OPEN;
            timer_d = '0;
            fail_d  = '0;
            good_d  = 1'b1;
          end else begin
            bad_d = 1'b1;
            if (fail_inc == TRIES_LIMIT) begin
              state_d = S_LOCKOUT;
              timer_d = '0;
              fail_d  = '0;
            end else begin
              fail_d = fail_inc[TRY_W-1:0];
            end
          end
        end
      end

      S_OPEN: begin
        if (relock || timer_q == UNLOCK_LAST) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (timer_q == LOCKOUT_LAST) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = S_LOCKED;
        timer_d = '0;
      end
    endcase

    // Status flops follow the next state so they line up with it exactly.
    unlocked_d = (state_d == S_OPEN);
    alarm_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOCKED;
      timer_q    <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign good_pulse = good_q;
  assign bad_pulse  = bad_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboard bench for lock_ctrl: a countdown-based reference model queues the
// expected outputs per driven cycle; a monitor pops and compares after each edge.
module tb_lock_ctrl;

  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 16;
  localparam int LOCKOUT_CYCLES = 64;
  localparam int TRY_W          = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic match = 1'b0;
  logic enter = 1'b0;
  logic relock = 1'b0;
  logic unlocked, alarm, good_pulse, bad_pulse;
  logic [TRY_W-1:0] fail_count;

  lock_ctrl #(
    .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .TRY_W(TRY_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .match(match),
    .enter(enter),
    .relock(relock),
    .unlocked(unlocked),
    .alarm(alarm),
    .good_pulse(good_pulse),
    .bad_pulse(bad_pulse),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Expected output word: {unlocked, alarm, good_pulse, bad_pulse, fail_count}
  logic [TRY_W+3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  // Reference model: remaining open / lockout cycles and consecutive failures.
  int open_left = 0;
  int lock_left = 0;
  int fails     = 0;

  task automatic step(input logic r, input logic e, input logic m, input logic rl);
    logic g, b;
    logic [TRY_W-1:0] fc;
    @(negedge clk);
    rst = r; enter = e; match = m; relock = rl;
    g = 1'b0; b = 1'b0;
    if (r) begin
      open_left = 0; lock_left = 0; fails = 0;
    end else if (open_left > 0) begin
      open_left = rl ? 0 : open_left - 1;
    end else if (lock_left > 0) begin
      lock_left = lock_left - 1;
    end else if (e) begin
      if (m) begin
        open_left = UNLOCK_CYCLES; fails = 0; g = 1'b1;
      end else begin
        b = 1'b1;
        fails = fails + 1;
        if (fails == MAX_TRIES) begin
          fails = 0; lock_left = LOCKOUT_CYCLES;
        end
      end
    end
    fc = TRY_W'(fails);
    exp_q.push_back({open_left > 0, lock_left > 0, g, b, fc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
  endtask

  initial begin : monitor
    logic [TRY_W+3:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {unlocked, alarm, good_pulse, bad_pulse, fail_count};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL outputs cycle=%0d got unl=%b alm=%b good=%b bad=%b fc=%0d required unl=%b alm=%b good=%b bad=%b fc=%0d",
                   cycle_no, got_v[TRY_W+3], got_v[TRY_W+2], got_v[TRY_W+1], got_v[TRY_W],
                   got_v[TRY_W-1:0], exp_v[TRY_W+3], exp_v[TRY_W+2], exp_v[TRY_W+1],
                   exp_v[TRY_W], exp_v[TRY_W-1:0]);
        end else begin
          $display("cycle=%0d unl=%b alm=%b good=%b bad=%b fc=%0d ok", cycle_no,
                   got_v[TRY_W+3], got_v[TRY_W+2], got_v[TRY_W+1], got_v[TRY_W], got_v[TRY_W-1:0]);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    // Reset then idle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Correct entry, full open period and close
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(UNLOCK_CYCLES + 3);
    // Three wrong entries into lockout, correct entry ignored during lockout
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(LOCKOUT_CYCLES);
    // Wrong then right, relock at the 5th open cycle
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Lockout aborted by reset at its 30th cycle, then a normal opening
    for (int i = 0; i < MAX_TRIES; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(29);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(UNLOCK_CYCLES + 2);
    // Wrong entry during OPEN is ignored; also enter on the closing cycle
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(UNLOCK_CYCLES - 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
